// File: rtl/rsn_ctrl_seq.sv
// -----------------------------------------------------------------------------
// rsn_ctrl_seq
//
// Control-side sequencer for a bank of flops that have both an active-low
// asynchronous reset (RN) and an active-low asynchronous set (SETN).
//
// Reset (RST) is asserted asynchronously. It is released synchronously through
// a synchroniser chain, followed by a programmable hold time. Once running,
// a 4-phase req/ack handshake requests a timed SETN or RN low pulse on the
// whole bank. RN and SETN are never low together.
//
// Ports:
//   CLK      in   clock, rising edge
//   RST      in   asynchronous reset, active-high
//   SET_REQ  in   level request for a bulk set pulse (4-phase)
//   CLR_REQ  in   level request for a bulk clear pulse (4-phase); wins ties
//   ACK      out  request completed; held until both requests are low
//   BUSY     out  high whenever the sequencer is not idle
//   RN       out  active-low reset to the flop bank
//   SETN     out  active-low set to the flop bank
//
// All outputs come directly from flops.
// -----------------------------------------------------------------------------
`timescale 1ns / 1ps

module rsn_ctrl_seq #(
    parameter int SYNC_STAGES  = 2,  // reset-release synchroniser depth (>= 2)
    parameter int HOLD_CYCLES  = 4,  // extra cycles RN stays low after release (>= 1)
    parameter int PULSE_CYCLES = 2,  // width of a requested SETN/RN pulse (>= 1)
    parameter int CNT_W        = 4   // holds max(HOLD_CYCLES, PULSE_CYCLES)
) (
    input  logic CLK,
    input  logic RST,
    input  logic SET_REQ,
    input  logic CLR_REQ,
    output logic ACK,
    output logic BUSY,
    output logic RN,
    output logic SETN
);

    typedef enum logic [2:0] {
        RST_HOLD,
        IDLE,
        SET_PULSE,
        CLR_PULSE,
        GUARD,
        ACK_WAIT
    } state_t;

    // Terminal counts: the counter starts at 0 on state entry, so the last
    // cycle of an N-cycle interval is the one where the count equals N-1.
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q,   cnt_d;
    logic [SYNC_STAGES-1:0] sync_q,  sync_d;
    logic                   rn_q,    rn_d;
    logic                   setn_q,  setn_d;
    logic                   ack_q,   ack_d;
    logic                   busy_q,  busy_d;

    // Synchronised reset: the last stage of the chain.
    logic sync_rst;
    assign sync_rst = sync_q[SYNC_STAGES-1];

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch can be inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        rn_d    = rn_q;
        setn_d  = setn_q;
        ack_d   = ack_q;
        // The chain only ever shifts zeros in; async reset refills it with ones.
        sync_d  = {sync_q[SYNC_STAGES-2:0], 1'b0};

        unique case (state_q)
            RST_HOLD: begin
                rn_d   = 1'b0;
                setn_d = 1'b1;
                ack_d  = 1'b0;
                if (!sync_rst) begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        rn_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            IDLE: begin
                rn_d   = 1'b1;
                setn_d = 1'b1;
                ack_d  = 1'b0;
                cnt_d  = '0;
                // Clear has priority; a simultaneous set request is dropped.
                if (CLR_REQ) begin
                    state_d = CLR_PULSE;
                    rn_d    = 1'b0;
                end else if (SET_REQ) begin
                    state_d = SET_PULSE;
                    setn_d  = 1'b0;
                end
            end

            SET_PULSE: begin
                rn_d = 1'b1;
                if (cnt_q == PULSE_LAST) begin
                    state_d = GUARD;
                    setn_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            CLR_PULSE: begin
                setn_d = 1'b1;
                if (cnt_q == PULSE_LAST) begin
                    state_d = GUARD;
                    rn_d    = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // One cycle with both pins high gives the bank recovery margin
            // before the requester is told the operation is done.
            GUARD: begin
                rn_d    = 1'b1;
                setn_d  = 1'b1;
                state_d = ACK_WAIT;
                ack_d   = 1'b1;
                cnt_d   = '0;
            end

            ACK_WAIT: begin
                rn_d   = 1'b1;
                setn_d = 1'b1;
                if (!SET_REQ && !CLR_REQ) begin
                    state_d = IDLE;
                    ack_d   = 1'b0;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = RST_HOLD;
                cnt_d   = '0;
                rn_d    = 1'b0;
                setn_d  = 1'b1;
                ack_d   = 1'b0;
            end
        endcase

        // Registered BUSY tracks the next state so it is valid with the state.
        busy_d = (state_d != IDLE);
    end

    // Every output is set by the same reset branch, so SETN returns high in
    // the same instant RN falls when RST interrupts a set pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= RST_HOLD;
            cnt_q   <= '0;
            sync_q  <= '1;
            rn_q    <= 1'b0;
            setn_q  <= 1'b1;
            ack_q   <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sync_q  <= sync_d;
            rn_q    <= rn_d;
            setn_q  <= setn_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    assign RN   = rn_q;
    assign SETN = setn_q;
    assign ACK  = ack_q;
    assign BUSY = busy_q;

endmodule

// File: tb/tb_rsn_ctrl_seq.sv
// -----------------------------------------------------------------------------
// tb_rsn_ctrl_seq
//
// Directed bench for rsn_ctrl_seq with default parameters. Expected output
// values are queued as each stimulus step is driven and popped and compared
// once the clock edge for that step has produced the DUT outputs. A negedge
// monitor checks the RN/SETN exclusion and ACK-only-when-busy properties
// throughout, including a random traffic phase.
// -----------------------------------------------------------------------------
`timescale 1ns / 1ps

module tb_rsn_ctrl_seq;

    localparam int SYNC  = 2;
    localparam int HOLD  = 4;
    localparam int PULSE = 2;
    localparam int LAT   = SYNC + HOLD;

    logic CLK;
    logic RST;
    logic SET_REQ;
    logic CLR_REQ;
    logic ACK;
    logic BUSY;
    logic RN;
    logic SETN;

    int checks = 0;
    int errors = 0;
    bit inv_en = 1'b0;

    typedef struct {
        string tag;
        logic  rn;
        logic  setn;
        logic  ack;
        logic  busy;
    } exp_t;

    exp_t sb[$];

    rsn_ctrl_seq #(
        .SYNC_STAGES (SYNC),
        .HOLD_CYCLES (HOLD),
        .PULSE_CYCLES(PULSE),
        .CNT_W       (4)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .SET_REQ(SET_REQ),
        .CLR_REQ(CLR_REQ),
        .ACK    (ACK),
        .BUSY   (BUSY),
        .RN     (RN),
        .SETN   (SETN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic rn, input logic setn,
                             input logic ack, input logic busy);
        check({tag, "_rn"},   RN,   rn);
        check({tag, "_setn"}, SETN, setn);
        check({tag, "_ack"},  ACK,  ack);
        check({tag, "_busy"}, BUSY, busy);
    endtask

    // Queue the expected outputs for the coming edge, let it happen, then
    // pop and compare.
    task automatic step(input string tag, input logic rn, input logic setn,
                        input logic ack, input logic busy);
        exp_t e;
        e.tag  = tag;
        e.rn   = rn;
        e.setn = setn;
        e.ack  = ack;
        e.busy = busy;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        check_all(e.tag, e.rn, e.setn, e.ack, e.busy);
    endtask

    // Drop RST now; RN must stay low for LAT-1 edges and rise on edge LAT.
    task automatic release_seq(input string tag);
        RST = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            step($sformatf("%s_e%0d", tag, k), (k == LAT), 1'b1, 1'b0, (k != LAT));
        end
    endtask

    // Invariants sampled away from the active edge.
    always @(negedge CLK) begin
        if (inv_en) begin
            check("inv_rn_or_setn", RN | SETN, 1'b1);
            check("inv_ack_idle", BUSY | ~ACK, 1'b1);
        end
    end

    initial begin
        RST     = 1'b0;
        SET_REQ = 1'b0;
        CLR_REQ = 1'b0;

        // ---------------- power-up ----------------
        #2 RST = 1'b1;
        #1 check_all("por_async", 1'b0, 1'b1, 1'b0, 1'b1);
        inv_en = 1'b1;
        for (int i = 0; i < 3; i++) step("por_hold", 1'b0, 1'b1, 1'b0, 1'b1);
        release_seq("por_rel");
        step("idle", 1'b1, 1'b1, 1'b0, 1'b0);

        // ---------------- set handshake ----------------
        SET_REQ = 1'b1;
        step("set_p1",    1'b1, 1'b0, 1'b0, 1'b1);
        step("set_p2",    1'b1, 1'b0, 1'b0, 1'b1);
        step("set_guard", 1'b1, 1'b1, 1'b0, 1'b1);
        step("set_ack",   1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step("set_ack_hold", 1'b1, 1'b1, 1'b1, 1'b1);
        SET_REQ = 1'b0;
        step("set_done",  1'b1, 1'b1, 1'b0, 1'b0);
        step("set_idle",  1'b1, 1'b1, 1'b0, 1'b0);

        // ---------------- clear + collision ----------------
        SET_REQ = 1'b1;
        CLR_REQ = 1'b1;
        step("clr_p1",    1'b0, 1'b1, 1'b0, 1'b1);
        step("clr_p2",    1'b0, 1'b1, 1'b0, 1'b1);
        step("clr_guard", 1'b1, 1'b1, 1'b0, 1'b1);
        step("clr_ack",   1'b1, 1'b1, 1'b1, 1'b1);
        SET_REQ = 1'b0;
        step("clr_ack_clrhi", 1'b1, 1'b1, 1'b1, 1'b1);
        CLR_REQ = 1'b0;
        step("clr_done",  1'b1, 1'b1, 1'b0, 1'b0);

        // ---------------- reset mid set pulse ----------------
        SET_REQ = 1'b1;
        step("mid_p1", 1'b1, 1'b0, 1'b0, 1'b1);
        step("mid_p2", 1'b1, 1'b0, 1'b0, 1'b1);
        #2 RST = 1'b1;
        SET_REQ = 1'b0;
        #1 check_all("mid_async", 1'b0, 1'b1, 1'b0, 1'b1);
        step("mid_hold", 1'b0, 1'b1, 1'b0, 1'b1);
        release_seq("mid_rel");
        step("mid_idle", 1'b1, 1'b1, 1'b0, 1'b0);

        // ---------------- glitch during hold ----------------
        RST = 1'b1;
        step("gl_hold", 1'b0, 1'b1, 1'b0, 1'b1);
        RST = 1'b0;
        for (int i = 0; i < 3; i++) step("gl_first", 1'b0, 1'b1, 1'b0, 1'b1);
        RST = 1'b1;
        step("gl_pulse", 1'b0, 1'b1, 1'b0, 1'b1);
        release_seq("gl_rel");

        // ---------------- random traffic (invariants) ----------------
        for (int i = 0; i < 10000; i++) begin
            @(posedge CLK);
            #1;
            RST     = ($urandom_range(0, 63) == 0);
            SET_REQ = 1'($urandom_range(0, 1));
            CLR_REQ = ($urandom_range(0, 3) == 0);
        end

        // Return to a known state and confirm a clean release.
        SET_REQ = 1'b0;
        CLR_REQ = 1'b0;
        RST     = 1'b1;
        step("end_hold", 1'b0, 1'b1, 1'b0, 1'b1);
        release_seq("end_rel");

        check("sb_empty", sb.size() == 0, 1'b1);
        inv_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
